telemetry_tx: RTL



---
 rtl/telemetry_tx.sv | 121 ++++++++++++
 1 files changed

// File: rtl/telemetry_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// telemetry_tx : periodic 8-byte telemetry packet sender over 8N1 UART
// Revision 1.0
// ---------------------------------------------------------------------------
module telemetry_tx #(
  parameter int FAST_SIM = 0,
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] batt,
  input  logic [11:0] avg_curr,
  input  logic [11:0] torque,
  output logic        TX,
  output logic        busy,
  output logic        pkt_done
);

  localparam int c_IW = (FAST_SIM != 0) ? 12 : 20;
  localparam int c_BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [c_IW-1:0] c_INTV_LAST = '1;
  localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(BAUD_DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t          r_state;
  logic [c_IW-1:0] r_intv;
  logic [c_BW-1:0] r_baud;
  logic [3:0]      r_bit;
  logic [2:0]      r_byte;
  logic [11:0]     r_batt;
  logic [11:0]     r_curr;
  logic [11:0]     r_torq;
  logic [7:0]      w_byte;
  logic            w_next_tx;

  always_comb begin
    w_byte = 8'hAA;
    case (r_byte)
      3'd0:    w_byte = 8'hAA;
      3'd1:    w_byte = 8'h55;
      3'd2:    w_byte = {4'h0, r_batt[11:8]};
      3'd3:    w_byte = r_batt[7:0];
      3'd4:    w_byte = {4'h0, r_curr[11:8]};
      3'd5:    w_byte = r_curr[7:0];
      3'd6:    w_byte = {4'h0, r_torq[11:8]};
      default: w_byte = r_torq[7:0];
    endcase
  end

  // Level for the bit that follows r_bit: data bits LSB first, then stop.
  always_comb begin
    w_next_tx = 1'b1;
    if (r_bit < 4'd8) w_next_tx = w_byte[r_bit[2:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_intv   <= '0;
      r_baud   <= '0;
      r_bit    <= '0;
      r_byte   <= '0;
      r_batt   <= '0;
      r_curr   <= '0;
      r_torq   <= '0;
      TX       <= 1'b1;
      busy     <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_intv == c_INTV_LAST) begin
            r_intv  <= '0;
            r_batt  <= batt;
            r_curr  <= avg_curr;
            r_torq  <= torque;
            r_byte  <= '0;
            r_bit   <= '0;
            r_baud  <= '0;
            TX      <= 1'b0;
            busy    <= 1'b1;
            r_state <= ST_SEND;
          end else begin
            r_intv <= r_intv + 1'b1;
          end
        end
        ST_SEND: begin
          if (r_baud == c_BAUD_LAST) begin
            r_baud <= '0;
            if (r_bit == 4'd9) begin
              r_bit <= '0;
              if (r_byte == 3'd7) begin
                r_state  <= ST_IDLE;
                busy     <= 1'b0;
                pkt_done <= 1'b1;
                TX       <= 1'b1;
              end else begin
                r_byte <= r_byte + 3'd1;
                TX     <= 1'b0;
              end
            end else begin
              r_bit <= r_bit + 4'd1;
              TX    <= w_next_tx;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
